// File: rtl/shift_iter_if.sv
// Request/result bundle for the iterative shifter: operand, shift amount and
// operation in; handshake flags and registered result out.
interface shift_iter_if;
   logic        start;
   logic [15:0] in;
   logic [3:0]  cnt;
   logic [1:0]  op;
   logic        ready;
   logic        busy;
   logic        done;
   logic [15:0] out;

   modport master (
      output start, in, cnt, op,
      input  ready, busy, done, out
   );

   modport slave (
      input  start, in, cnt, op,
      output ready, busy, done, out
   );
endinterface

// File: rtl/shift_iter.sv
// Iterative 16-bit rotate/shift unit: moves the operand one bit per clock and
// registers the result on the edge that enters DONE.
//
// state | meaning
// IDLE  | ready for a new request; start samples in/cnt/op
// SHIFT | one bit of movement per edge, r counts remaining steps
// DONE  | one-cycle done pulse, out holds the finished result
module shift_iter (
   input  logic       clk,
   input  logic       rst_n,
   shift_iter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] w;
   logic [15:0] w_shft;
   logic [15:0] out_q;
   logic [3:0]  r;
   logic [1:0]  op_q;
   logic        accept;
   logic        ready;
   logic        busy;
   logic        done;

   assign accept = (state == IDLE) && bus.start;

   always_comb begin
      w_shft = w;
      case (op_q)
         2'b00:   w_shft = {w[14:0], w[15]};
         2'b01:   w_shft = {w[14:0], 1'b0};
         2'b10:   w_shft = {w[0], w[15:1]};
         default: w_shft = {1'b0, w[15:1]};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = (bus.cnt == 4'd0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            // r is never 0 here; <= guards against wrapping if it ever were
            if (r <= 4'd1) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      case (state)
         IDLE:  ready = 1'b1;
         SHIFT: busy  = 1'b1;
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w     <= 16'h0000;
         r     <= 4'd0;
         op_q  <= 2'b00;
         out_q <= 16'h0000;
      end else if (accept) begin
         w    <= bus.in;
         r    <= bus.cnt;
         op_q <= bus.op;
         if (bus.cnt == 4'd0) begin
            out_q <= bus.in;
         end
      end else if (state == SHIFT) begin
         w <= w_shft;
         if (r != 4'd0) begin
            r <= r - 4'd1;
         end
         if (r <= 4'd1) begin
            out_q <= w_shft;
         end
      end
   end

   assign bus.ready = ready;
   assign bus.busy  = busy;
   assign bus.done  = done;
   assign bus.out   = out_q;

endmodule

// File: tb/tb_shift_iter.sv
// Self-checking bench for shift_iter: directed vector table, reset/back-to-back
// sequences, and random operations against an arithmetic reference model.
module tb_shift_iter;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   cyc;
   int   done_cyc;

   shift_iter_if bus ();

   shift_iter u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] in;
      logic [3:0]  cnt;
      logic [1:0]  op;
      logic [15:0] exp_out;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] model(input logic [15:0] x, input int n, input logic [1:0] op);
      logic [31:0] xx;
      logic [31:0] res;
      xx = {16'h0000, x};
      case (op)
         2'd0:    res = (xx << n) | (xx >> (16 - n));
         2'd1:    res = xx << n;
         2'd2:    res = (xx >> n) | (xx << (16 - n));
         default: res = xx >> n;
      endcase
      return res[15:0];
   endfunction

   // Issue one request, scramble the inputs while it runs, and check latency,
   // result, hold of out during the run, and the return to IDLE.
   task automatic run_op(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o,
                         input logic [15:0] expv, input string name);
      int          g;
      int          lat;
      logic [15:0] prev;
      logic        hold_bad;
      g = 0;
      while (bus.ready !== 1'b1 && g < 40) begin
         @(negedge clk);
         g++;
      end
      if (bus.ready !== 1'b1) chk({name, "_ready_wait"}, {31'd0, bus.ready}, 32'd1);
      prev     = bus.out;
      hold_bad = 1'b0;
      bus.start = 1'b1;
      bus.in    = a;
      bus.cnt   = c;
      bus.op    = o;
      @(negedge clk);
      lat = 1;
      while (bus.done !== 1'b1 && lat < 20) begin
         if (bus.out !== prev) hold_bad = 1'b1;
         bus.start = 1'($urandom);
         bus.in    = 16'($urandom);
         bus.cnt   = 4'($urandom);
         bus.op    = 2'($urandom);
         @(negedge clk);
         lat++;
      end
      done_cyc  = cyc;
      bus.start = 1'b0;
      chk({name, "_latency"}, lat, c + 1);
      chk({name, "_out"}, {16'd0, bus.out}, {16'd0, expv});
      chk({name, "_flags_done"}, {29'd0, bus.ready, bus.busy, bus.done}, 32'd3);
      chk({name, "_out_hold"}, {31'd0, hold_bad}, 32'd0);
      @(negedge clk);
      chk({name, "_flags_idle"}, {29'd0, bus.ready, bus.busy, bus.done}, 32'd4);
      chk({name, "_out_after"}, {16'd0, bus.out}, {16'd0, expv});
   endtask

   initial begin
      int          prev_done;
      int          npulse;
      logic [15:0] ra;
      logic [3:0]  rc;
      logic [1:0]  ro;

      checks    = 0;
      failures  = 0;
      done_cyc  = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.in    = 16'h0000;
      bus.cnt   = 4'd0;
      bus.op    = 2'b00;

      vecs.push_back('{16'h8001, 4'd1,  2'b00, 16'h0003, "rotl1"});
      vecs.push_back('{16'h8001, 4'd4,  2'b01, 16'h0010, "shl4"});
      vecs.push_back('{16'h8001, 4'd15, 2'b10, 16'h0003, "rotr15"});
      vecs.push_back('{16'h8001, 4'd15, 2'b00, 16'hC000, "rotl15"});
      vecs.push_back('{16'hFFFF, 4'd15, 2'b01, 16'h8000, "shl15"});
      vecs.push_back('{16'hFFFF, 4'd15, 2'b11, 16'h0001, "shr15"});
      vecs.push_back('{16'hA5C3, 4'd0,  2'b11, 16'hA5C3, "cnt0"});
      vecs.push_back('{16'h0F0F, 4'd8,  2'b10, 16'h0F0F, "rotr8"});

      #3;
      chk("reset_flags", {29'd0, bus.ready, bus.busy, bus.done}, 32'd4);
      chk("reset_out", {16'd0, bus.out}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         run_op(vecs[i].in, vecs[i].cnt, vecs[i].op, vecs[i].exp_out, vecs[i].name);
      end

      // back-to-back: second request accepted in the IDLE cycle after DONE
      run_op(16'hF000, 4'd12, 2'b11, 16'h000F, "shr12");
      prev_done = done_cyc;
      run_op(16'h1234, 4'd0, 2'b00, 16'h1234, "b2b_cnt0");
      chk("b2b_done_spacing", done_cyc - prev_done, 32'd2);

      // abort mid-shift; start held high during reset must be ignored
      run_op(16'h00FF, 4'd0, 2'b00, 16'h00FF, "pre_abort");
      bus.start = 1'b1;
      bus.in    = 16'h1357;
      bus.cnt   = 4'd10;
      bus.op    = 2'b00;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      bus.start = 1'b1;
      #1;
      chk("abort_flags", {29'd0, bus.ready, bus.busy, bus.done}, 32'd4);
      chk("abort_out", {16'd0, bus.out}, 32'd0);
      npulse = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.ready !== 1'b1) npulse++;
      end
      bus.start = 1'b0;
      rst_n     = 1'b1;
      repeat (15) begin
         @(negedge clk);
         if (bus.done === 1'b1) npulse++;
      end
      chk("abort_no_done", npulse, 32'd0);
      chk("abort_out_held", {16'd0, bus.out}, 32'd0);

      // first edge out of reset accepts a request normally
      rst_n = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      bus.start = 1'b1;
      bus.in    = 16'hBEEF;
      bus.cnt   = 4'd0;
      bus.op    = 2'b01;
      @(negedge clk);
      bus.start = 1'b0;
      chk("post_reset_done", {31'd0, bus.done}, 32'd1);
      chk("post_reset_out", {16'd0, bus.out}, 32'h0000BEEF);
      @(negedge clk);

      for (int k = 0; k < 150; k++) begin
         ra = 16'($urandom);
         rc = 4'($urandom);
         ro = 2'($urandom);
         run_op(ra, rc, ro, model(ra, int'(rc), ro), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule

// File: doc/shift_iter.md
SHIFT_ITER -- requirements
Module: shift_iter

Interface
REQ-001 The module SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 Start  input  1  request to begin a shift operation; sampled only while Ready=1.
REQ-005 In  input  16  operand, captured on the accepted Start edge.
REQ-006 Cnt  input  4  shift amount 0..15, captured on the accepted Start edge.
REQ-007 Op  input  2  operation, captured on the accepted Start edge:
- 00 = rotate left.
- 01 = shift left logical.
- 10 = rotate right.
- 11 = shift right logical.
REQ-008 Ready  output  1  high only in IDLE; a new operation can be accepted.
REQ-009 Busy  output  1  high in SHIFT and DONE.
REQ-010 Done  output  1  one-cycle pulse; Out holds the completed result.
REQ-011 Out  output  16  last completed result, registered.

Function
REQ-012 The FSM SHALL have exactly three states:
- IDLE: Ready=1, Busy=0, Done=0.
- SHIFT: Ready=0, Busy=1, Done=0.
- DONE: Ready=0, Busy=1, Done=1.
REQ-013 IDLE with Start=1 at a clock edge SHALL load working register W<=In, remaining count R<=Cnt and operation register <=Op.
- The next state SHALL be SHIFT if Cnt!=0, or DONE if Cnt=0.
REQ-014 IDLE with Start=0 SHALL remain in IDLE with all registers unchanged.
REQ-015 Each SHIFT-state edge SHALL move W by exactly one bit per the captured Op and decrement R by 1.
- Rotate left: bit15 enters bit0.
- Shift left logical: 0 enters bit0.
- Rotate right: bit0 enters bit15.
- Shift right logical: 0 enters bit15.
REQ-016 When R=1 at a SHIFT edge, the next state SHALL be DONE and Out SHALL load the final shifted W on that same edge.
REQ-017 Entry to DONE from IDLE (Cnt=0) SHALL load Out<=In unchanged.
REQ-018 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-019 Latency SHALL be Cnt+1 cycles: Done is high in the cycle following the (Cnt+1)th rising edge, counting the accepting edge as the 1st.
REQ-020 Start SHALL be ignored in SHIFT and DONE, and In/Cnt/Op changes there SHALL NOT affect the operation in flight.
REQ-021 Start asserted in the cycle immediately after DONE (state IDLE) SHALL be accepted, giving back-to-back operations with one idle cycle between Done pulses.
REQ-022 Out SHALL change only on entry to DONE or on reset.
- Out SHALL hold its value through IDLE and SHIFT.
REQ-023 Cnt=15 with a rotate op SHALL equal a 1-bit rotate in the opposite direction.
REQ-024 Shift-logical ops with Cnt=15 SHALL leave only one original bit.
REQ-025 The count SHALL NOT wrap: R never decrements below 0, and SHIFT is never entered with R=0.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE, Ready=1, Busy=0, Done=0, Out=16'h0000, W=0, R=0, operation register=00.
REQ-027 A reset asserted mid-SHIFT or in DONE SHALL abort the operation.
- No Done pulse SHALL occur for the aborted operation.
- Out SHALL read 16'h0000.
REQ-028 Start SHALL be ignored while rst_n=0.
REQ-029 The first edge with rst_n=1 SHALL behave as a normal IDLE edge.

Verification
REQ-030 In=16'h8001, Cnt=1, Op=00 -> Done pulse 2 cycles after the Start edge, Out=16'h0003.
REQ-031 In=16'h8001, Cnt=4, Op=01 -> Done after 5 cycles, Out=16'h0010.
REQ-032 In=16'h8001, Cnt=15, Op=10 -> Done after 16 cycles, Out=16'h0003.
REQ-033 In=16'hF000, Cnt=12, Op=11 -> Out=16'h000F; then In=16'h1234, Cnt=0 accepted the cycle after Done -> Done next cycle, Out=16'h1234.
REQ-034 Start re-pulsed with different In/Cnt during SHIFT -> ignored; the original result is produced at the original latency.
REQ-035 rst_n pulsed low at cycle 3 of a Cnt=10 operation -> Ready=1, Out=16'h0000 immediately, and no Done pulse.
